// File: rtl/dmem_responder.sv
// LC-3b MEM-stage data memory responder with programmable wait states.
// Define DMEM_RANGE_CHECK_EN to add mem_err for out-of-range addresses.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_byte_enable,
   output logic        mem_resp,
`ifdef DMEM_RANGE_CHECK_EN
   output logic        mem_err,
`endif
   output logic [15:0] mem_rdata
);

   localparam int IW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          resp_q, resp_d;
   logic [15:0]   rdata_q, rdata_d;
   logic [15:0]   mem_q [DEPTH_WORDS];

   logic [IW-1:0] idx;
   logic          req;
   logic          enter;
   logic          oor;
   logic          we_lo;
   logic          we_hi;

   assign req = mem_read | mem_write;
   assign idx = mem_address[IW:1];

`ifdef DMEM_RANGE_CHECK_EN
   logic err_q, err_d;
   assign oor = (mem_address >> (IW + 1)) != 16'h0000;
`else
   assign oor = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               if (LATENCY == 1) begin
                  state_d = S_RESP;
               end else begin
                  cnt_d   = 4'(LATENCY - 2);
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!req) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The array is touched only on the edge that enters RESP.
   always_comb begin
      enter   = (state_d == S_RESP);
      resp_d  = enter;
      rdata_d = rdata_q;
      if (enter && mem_read) begin
         rdata_d = oor ? 16'h0000 : mem_q[idx];
      end
      we_lo = enter & mem_write & mem_byte_enable[0] & ~oor & reset_n;
      we_hi = enter & mem_write & mem_byte_enable[1] & ~oor & reset_n;
`ifdef DMEM_RANGE_CHECK_EN
      err_d = enter & oor;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         resp_q  <= 1'b0;
         rdata_q <= 16'h0000;
`ifdef DMEM_RANGE_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
         rdata_q <= rdata_d;
`ifdef DMEM_RANGE_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (we_lo) begin
         mem_q[idx][7:0] <= mem_wdata[7:0];
      end
      if (we_hi) begin
         mem_q[idx][15:8] <= mem_wdata[15:8];
      end
   end

   assign mem_resp  = resp_q;
   assign mem_rdata = rdata_q;
`ifdef DMEM_RANGE_CHECK_EN
   assign mem_err   = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, DEPTH_WORDS=256).
// Covers DMEM_RANGE_CHECK_EN when the macro is defined for the build.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        reset_n;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;
`ifdef DMEM_RANGE_CHECK_EN
  logic        mem_err;
`endif

  int vec  = 0;
  int miss = 0;
  int hits [$];

  dmem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mem_address(mem_address),
    .mem_wdata(mem_wdata),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp),
`ifdef DMEM_RANGE_CHECK_EN
    .mem_err(mem_err),
`endif
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    if (obs !== exp) begin
      miss++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic rd, input logic wr,
                      input logic [15:0] a,
                      input logic [15:0] wd,
                      input logic [1:0] be,
                      input logic [15:0] exp,
                      input logic exp_err,
                      input string tag);
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = a;
    mem_wdata       = wd;
    mem_byte_enable = be;
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      chk({tag, "_early"}, mem_resp, 1'b0);
    end
    @(negedge clk);
    chk({tag, "_resp"}, mem_resp, 1'b1);
    chk({tag, "_rdata"}, mem_rdata, exp);
`ifdef DMEM_RANGE_CHECK_EN
    chk({tag, "_err"}, mem_err, exp_err);
`endif
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, mem_resp, 1'b0);
  endtask

  initial begin
    reset_n         = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = 16'h0000;
    mem_wdata       = 16'h0000;
    mem_byte_enable = 2'b00;
    repeat (2) @(negedge clk);
    vec++;
    if (mem_resp !== 1'b0 || mem_rdata !== 16'h0000) begin
      miss++;
      $error("FAIL rst_state resp=%b rdata=%h",
             mem_resp, mem_rdata);
    end
    reset_n = 1'b1;
    @(negedge clk);

    xfer(0, 1, 16'h0040, 16'hBEEF, 2'b11,
         16'h0000, 0, "t1_wr");
    xfer(1, 0, 16'h0040, 16'h0000, 2'b00,
         16'hBEEF, 0, "t1_rd");

    xfer(0, 1, 16'h0010, 16'h1234, 2'b11,
         16'hBEEF, 0, "t2_pre");
    xfer(0, 1, 16'h0010, 16'hAB00, 2'b10,
         16'hBEEF, 0, "t2_hi");
    xfer(1, 0, 16'h0010, 16'h0000, 2'b00,
         16'hAB34, 0, "t2_rdhi");
    xfer(0, 1, 16'h0010, 16'h00CD, 2'b01,
         16'hAB34, 0, "t2_lo");
    xfer(1, 0, 16'h0010, 16'h0000, 2'b00,
         16'hABCD, 0, "t2_rdlo");
    xfer(0, 1, 16'h0010, 16'hFFFF, 2'b00,
         16'hABCD, 0, "t2_be0");
    xfer(1, 0, 16'h0010, 16'h0000, 2'b00,
         16'hABCD, 0, "t2_rdbe0");

    xfer(0, 1, 16'h0020, 16'h0000, 2'b11,
         16'hABCD, 0, "t3_pre");
    mem_address     = 16'h0020;
    mem_wdata       = 16'h5555;
    mem_byte_enable = 2'b11;
    mem_write       = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vec++;
      if (mem_resp !== 1'b0) begin
        miss++;
        $error("FAIL t3_noresp resp=%b after abort",
               mem_resp);
      end
    end
    chk("t3_hold", mem_rdata, 16'hABCD);
    xfer(1, 0, 16'h0020, 16'h0000, 2'b00,
         16'h0000, 0, "t3_rd");

    xfer(1, 1, 16'h0020, 16'h6666, 2'b11,
         16'h0000, 0, "t4_rbw");
    xfer(1, 0, 16'h0020, 16'h0000, 2'b00,
         16'h6666, 0, "t4_rbwrd");
    mem_address = 16'h0040;
    mem_read    = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (mem_resp) hits.push_back(k);
    end
    mem_read = 1'b0;
    @(negedge clk);
    chk("t4_nhits", hits.size(), 2);
    if (hits.size() == 2) begin
      chk("t4_first", hits[0], LAT);
      chk("t4_space", hits[1] - hits[0], LAT + 1);
    end
    chk("t4_rdata", mem_rdata, 16'hBEEF);

    mem_address     = 16'h0040;
    mem_wdata       = 16'h1111;
    mem_byte_enable = 2'b11;
    mem_write       = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_resp", mem_resp, 1'b0);
    chk("t5_rdata", mem_rdata, 16'h0000);
    @(negedge clk);
    mem_write = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);
    chk("t5_idle", mem_resp, 1'b0);
    xfer(1, 0, 16'h0040, 16'h0000, 2'b00,
         16'hBEEF, 0, "t5_rd");

`ifdef DMEM_RANGE_CHECK_EN
    xfer(0, 1, 16'h0002, 16'h4242, 2'b11,
         16'hBEEF, 0, "t6_pre");
    xfer(0, 1, 16'h0202, 16'h7777, 2'b11,
         16'hBEEF, 1, "t6_oorwr");
    xfer(1, 0, 16'h0002, 16'h0000, 2'b00,
         16'h4242, 0, "t6_rd");
    xfer(1, 0, 16'h0202, 16'h0000, 2'b00,
         16'h0000, 1, "t6_oorrd");
`else
    xfer(0, 1, 16'h0202, 16'h7777, 2'b11,
         16'hBEEF, 0, "t6_wr");
    xfer(1, 0, 16'h0002, 16'h0000, 2'b00,
         16'h7777, 0, "t6_alias");
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule
